toggle_activity_monitor: RTL and testbench

Switching-activity counter for power sub-circuit experiments. It sits directly downstream of a synthesized sub-circuit under test and samples the sub-circuit's primary inputs and outputs as one packed bus. Over a programmable window of clock cycles it counts 0↔1 transitions per signal and in total. Host logic reads the counts after a start/done handshake to estimate dynamic power.

---
 rtl/toggle_activity_monitor.sv | 126 ++++++++++++
 tb/tb_toggle_activity_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/toggle_activity_monitor.sv
// rtl/toggle_activity_monitor.sv - per-signal and total 0<->1 transition counter over a programmable window
module toggle_activity_monitor #(
    parameter int NUM_SIG = 5,
    parameter int CNT_W   = 16,
    parameter int TOT_W   = 19,
    parameter int WIN_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIN_W-1:0]   win_len,
    input  logic [NUM_SIG-1:0] sig_in,
    input  logic [2:0]         sel,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   cnt_out,
    output logic [TOT_W-1:0]   total_out,
    output logic               overflow
);

    typedef enum logic [1:0] {IDLE, PRIME, MEASURE, FINISH} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIN_W-1:0] REM_ONE = WIN_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q [NUM_SIG];
    logic [CNT_W-1:0]   count_d [NUM_SIG];
    logic [TOT_W-1:0]   total_q, total_d;
    logic [NUM_SIG-1:0] prev_q, prev_d;
    logic [WIN_W-1:0]   rem_q, rem_d;
    logic               ovf_q, ovf_d;

    logic [NUM_SIG-1:0] diff;
    logic [TOT_W:0]     pop;
    logic [TOT_W:0]     tot_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_SIG; i++) count_q[i] <= '0;
            total_q <= '0;
            prev_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < NUM_SIG; i++) count_q[i] <= count_d[i];
            total_q <= total_d;
            prev_q  <= prev_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = PRIME;
            PRIME:   state_d = (rem_q != '0) ? MEASURE : FINISH;
            MEASURE: if (rem_q == REM_ONE) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == PRIME) || (state_q == MEASURE);
        done = (state_q == FINISH);
    end

    // Sum in one extra bit so a carry out of TOT_W marks a clipped add.
    always_comb begin
        diff = sig_in ^ prev_q;
        pop  = '0;
        for (int i = 0; i < NUM_SIG; i++) pop = pop + {{TOT_W{1'b0}}, diff[i]};
        tot_sum = {1'b0, total_q} + pop;
    end

    always_comb begin
        for (int i = 0; i < NUM_SIG; i++) count_d[i] = count_q[i];
        total_d = total_q;
        prev_d  = prev_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < NUM_SIG; i++) count_d[i] = '0;
                    total_d = '0;
                    ovf_d   = 1'b0;
                    rem_d   = win_len;
                end
            end
            PRIME: prev_d = sig_in;
            MEASURE: begin
                for (int i = 0; i < NUM_SIG; i++) begin
                    if (diff[i]) begin
                        if (count_q[i] == '1) ovf_d = 1'b1;
                        else count_d[i] = count_q[i] + CNT_ONE;
                    end
                end
                if (tot_sum[TOT_W]) begin
                    total_d = '1;
                    ovf_d   = 1'b1;
                end else begin
                    total_d = tot_sum[TOT_W-1:0];
                end
                prev_d = sig_in;
                rem_d  = rem_q - REM_ONE;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < NUM_SIG; i++) begin
            if (sel == 3'(i)) cnt_out = count_q[i];
        end
    end

    assign total_out = total_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// tb/tb_toggle_activity_monitor.sv - directed self-checking bench for toggle_activity_monitor
module tb_toggle_activity_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] win_len;
    logic [4:0]  sig_in;
    logic [2:0]  sel;
    logic        busy, done, overflow;
    logic [15:0] cnt_out;
    logic [18:0] total_out;
    logic        busy_s, done_s, overflow_s;
    logic [3:0]  cnt_out_s;
    logic [18:0] total_out_s;

    int n_cmp = 0;
    int n_err = 0;

    toggle_activity_monitor u_dut (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len), .sig_in(sig_in),
        .sel(sel), .busy(busy), .done(done), .cnt_out(cnt_out),
        .total_out(total_out), .overflow(overflow)
    );

    toggle_activity_monitor #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len), .sig_in(sig_in),
        .sel(sel), .busy(busy_s), .done(done_s), .cnt_out(cnt_out_s),
        .total_out(total_out_s), .overflow(overflow_s)
    );

    always #5 clk = ~clk;

    // Accept a start, then run a fixed number of cycles toggling sig_in by tog each cycle.
    task automatic run_window(input logic [15:0] win, input logic [4:0] tog, input int restart_at,
                              input int cycles, output int first_done, output int n_done);
        first_done = 0;
        n_done     = 0;
        @(negedge clk);
        start   = 1'b1;
        win_len = win;
        @(posedge clk);
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (done) begin
                n_done++;
                if (first_done == 0) first_done = c;
            end
            sig_in = sig_in ^ tog;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            sig_in = 5'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", done); end
        n_cmp++; if (total_out !== 19'd0) begin n_err++; $display("FAIL reset_total got %0d want 0", total_out); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", overflow); end
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            n_cmp++; if (cnt_out !== 16'd0) begin n_err++; $display("FAIL reset_cnt sel=%0d got %0d want 0", s, cnt_out); end
        end
    endtask

    task automatic test_quiet();
        int fd, nd;
        sig_in = 5'b01101;
        run_window(16'd8, 5'b00000, 0, 14, fd, nd);
        n_cmp++; if (fd !== 10) begin n_err++; $display("FAIL quiet_latency got %0d want 10", fd); end
        n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL quiet_ndone got %0d want 1", nd); end
        n_cmp++; if (total_out !== 19'd0) begin n_err++; $display("FAIL quiet_total got %0d want 0", total_out); end
        for (int s = 0; s < 5; s++) begin
            sel = 3'(s);
            #1;
            n_cmp++; if (cnt_out !== 16'd0) begin n_err++; $display("FAIL quiet_cnt sel=%0d got %0d want 0", s, cnt_out); end
        end
    endtask

    task automatic test_single_toggler();
        int fd, nd;
        sig_in = 5'b10100;
        run_window(16'd10, 5'b00001, 0, 15, fd, nd);
        n_cmp++; if (fd !== 12) begin n_err++; $display("FAIL single_latency got %0d want 12", fd); end
        n_cmp++; if (total_out !== 19'd10) begin n_err++; $display("FAIL single_total got %0d want 10", total_out); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL single_ovf got %0b want 0", overflow); end
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            n_cmp++;
            if (cnt_out !== ((s == 0) ? 16'd10 : 16'd0)) begin
                n_err++; $display("FAIL single_cnt sel=%0d got %0d want %0d", s, cnt_out, (s == 0) ? 10 : 0);
            end
        end
    endtask

    task automatic test_saturation();
        int fd, nd;
        sig_in = 5'b00000;
        run_window(16'd20, 5'b11111, 0, 25, fd, nd);
        n_cmp++; if (total_out_s !== 19'd100) begin n_err++; $display("FAIL sat_total got %0d want 100", total_out_s); end
        n_cmp++; if (overflow_s !== 1'b1) begin n_err++; $display("FAIL sat_ovf got %0b want 1", overflow_s); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL wide_ovf got %0b want 0", overflow); end
        for (int s = 0; s < 5; s++) begin
            sel = 3'(s);
            #1;
            n_cmp++; if (cnt_out_s !== 4'd15) begin n_err++; $display("FAIL sat_cnt sel=%0d got %0d want 15", s, cnt_out_s); end
            n_cmp++; if (cnt_out !== 16'd20) begin n_err++; $display("FAIL wide_cnt sel=%0d got %0d want 20", s, cnt_out); end
        end
    endtask

    task automatic test_zero_and_ignored_start();
        int fd, nd;
        sig_in = 5'b00000;
        run_window(16'd0, 5'b11111, 0, 5, fd, nd);
        n_cmp++; if (fd !== 2) begin n_err++; $display("FAIL zero_latency got %0d want 2", fd); end
        n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL zero_ndone got %0d want 1", nd); end
        n_cmp++; if (total_out !== 19'd0) begin n_err++; $display("FAIL zero_total got %0d want 0", total_out); end
        run_window(16'd6, 5'b00010, 3, 14, fd, nd);
        n_cmp++; if (fd !== 8) begin n_err++; $display("FAIL ignored_latency got %0d want 8", fd); end
        n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL ignored_ndone got %0d want 1", nd); end
        n_cmp++; if (total_out !== 19'd6) begin n_err++; $display("FAIL ignored_total got %0d want 6", total_out); end
    endtask

    task automatic test_reset_mid_window();
        int fd, nd;
        sig_in = 5'b00000;
        fd = 0;
        nd = 0;
        @(negedge clk);
        start   = 1'b1;
        win_len = 16'd50;
        @(posedge clk);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 21) begin
                n_cmp++; if (total_out !== 19'd38) begin n_err++; $display("FAIL midrst_partial got %0d want 38", total_out); end
                rst = 1'b1;
            end
            sig_in = sig_in ^ 5'b00011;
        end
        @(negedge clk);
        sel = 3'd0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got %0b want 0", done); end
        n_cmp++; if (total_out !== 19'd0) begin n_err++; $display("FAIL midrst_total got %0d want 0", total_out); end
        n_cmp++; if (cnt_out !== 16'd0) begin n_err++; $display("FAIL midrst_cnt got %0d want 0", cnt_out); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL midrst_ovf got %0b want 0", overflow); end
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) fd++;
        end
        n_cmp++; if (nd !== 0) begin n_err++; $display("FAIL midrst_nodone got %0d want 0", nd); end
        n_cmp++; if (fd !== 0) begin n_err++; $display("FAIL midrst_idle busy_cycles got %0d want 0", fd); end
        sig_in = 5'b00000;
        run_window(16'd4, 5'b10000, 0, 8, fd, nd);
        n_cmp++; if (fd !== 6) begin n_err++; $display("FAIL fresh_latency got %0d want 6", fd); end
        n_cmp++; if (total_out !== 19'd4) begin n_err++; $display("FAIL fresh_total got %0d want 4", total_out); end
        sel = 3'd4;
        #1;
        n_cmp++; if (cnt_out !== 16'd4) begin n_err++; $display("FAIL fresh_cnt4 got %0d want 4", cnt_out); end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        win_len = 16'd0;
        sig_in  = 5'd0;
        sel     = 3'd0;
        test_reset();
        test_quiet();
        test_single_toggler();
        test_saturation();
        test_zero_and_ignored_start();
        test_reset_mid_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
